// File: rtl/apb_ic_arbiter_v2_pkg.sv
// Shared APB interconnect definitions: default master count and index-width helper.
package apb_ic_arbiter_v2_pkg;

  localparam int NUM_MASTERS_DEF = 4;

  // Index width for n masters: clog2(n), but never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Rotating priority encoder: finds the first set request at or after 'start',
// wrapping modulo N. Purely combinational.
module apb_rr_pick
  import apb_ic_arbiter_v2_pkg::*;
#(
  parameter int N  = NUM_MASTERS_DEF,
  parameter int IW = idx_w(NUM_MASTERS_DEF)
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] index,
  output logic [N-1:0]  onehot
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;
  int             pos;

  // Rotate requests so that 'start' lands on bit 0, then pick the lowest set bit
  // and map it back to an absolute master index.
  always_comb begin
    dbl = {reqs, reqs} >> start;
    rot = dbl[N-1:0];
    off = 0;
    // Scan high to low so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      off = rot[i] ? i : off;
    end
    pos    = int'(start) + off;
    pos    = (pos >= N) ? (pos - N) : pos;
    valid  = |rot;
    index  = IW'(pos);
    onehot = valid ? (N'(1) << pos) : {N{1'b0}};
  end

endmodule

// File: rtl/apb_ic_arbiter_v2.sv
// Round-robin APB bus arbiter with ownership lock and a registered,
// always-one-hot grant vector that parks on the last owner when idle.
module apb_ic_arbiter_v2
  import apb_ic_arbiter_v2_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] reqs,
  output logic [NUM_MASTERS-1:0] grants
);

  localparam int IDX_W = idx_w(NUM_MASTERS);

  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       start;
  logic                   lock;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_index;
  logic [NUM_MASTERS-1:0] pick_onehot;

  // Search begins just past the current owner, so the owner is considered last.
  always_comb begin
    if (int'(last) >= NUM_MASTERS - 1) begin
      start = {IDX_W{1'b0}};
    end else begin
      start = last + IDX_W'(1);
    end
    lock = reqs[last];
  end

  apb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IDX_W)
  ) u_pick (
    .reqs   (reqs),
    .start  (start),
    .valid  (pick_valid),
    .index  (pick_index),
    .onehot (pick_onehot)
  );

  // Ownership register: reset to master 0, hold while locked or idle, else hand over.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grants <= NUM_MASTERS'(1);
      last   <= {IDX_W{1'b0}};
    end else if (lock) begin
      grants <= grants;
      last   <= last;
    end else if (pick_valid) begin
      grants <= pick_onehot;
      last   <= pick_index;
    end else begin
      grants <= grants;
      last   <= last;
    end
  end

endmodule

// File: tb/tb_apb_ic_arbiter_v2.sv
// Self-checking bench for apb_ic_arbiter_v2: directed vector table, a fairness
// rotation sequence, and randomized traffic against an owner-index model.
module tb_apb_ic_arbiter_v2;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] reqs;
  logic [N-1:0] grants;

  int n_checks = 0;
  int n_pass   = 0;
  int owner    = 0;   // reference model: index of the master that owns the bus

  typedef struct {
    logic         rst;
    logic [N-1:0] rq;
    logic [N-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  apb_ic_arbiter_v2 #(.NUM_MASTERS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .reqs   (reqs),
    .grants (grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next owner from the arbitration rules: reset -> 0, lock if owner still
  // requests, otherwise first requester after the owner going round the ring.
  function automatic int model_next(int own, logic rst, logic [N-1:0] r);
    int cand;
    if (rst == 1'b0) return 0;
    if (r[own] == 1'b1) return own;
    for (int k = 1; k <= N; k++) begin
      cand = (own + k) % N;
      if (r[cand] == 1'b1) return cand;
    end
    return own;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: grants=%b expected=%b (t=%0t)", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs, advance the model, and check grants against it.
  task automatic step(input logic rst, input logic [N-1:0] r, input string name);
    logic [N-1:0] mexp;
    reset = rst;
    reqs  = r;
    @(posedge clk);
    #1;
    owner = model_next(owner, rst, r);
    mexp  = N'(1) << owner;
    chk({name, "/model"}, grants, mexp);
    n_checks++;
    if ($onehot(grants)) n_pass++;
    else $display("FAIL %s/onehot: grants=%b expected one-hot", name, grants);
  endtask

  task automatic add(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.rq = rq; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [N-1:0] r;
    logic         rs;
    int           cur;

    reset = 1'b0;
    reqs  = '0;

    // Directed table: each row is one clock edge.
    for (int i = 0; i < 5; i++) add(1'b0, 4'b0000, 4'b0001, "reset");
    add(1'b1, 4'b0000, 4'b0001, "reset_release");
    for (int i = 0; i < 5; i++) add(1'b1, 4'b0001, 4'b0001, "self_hold");
    add(1'b1, 4'b0100, 4'b0100, "handover_2");
    add(1'b1, 4'b1000, 4'b1000, "handover_3");
    add(1'b1, 4'b0010, 4'b0010, "lock_setup");
    for (int i = 0; i < 4; i++) add(1'b1, 4'b1110, 4'b0010, "lock_hold");
    add(1'b1, 4'b1100, 4'b0100, "lock_release");
    add(1'b1, 4'b1000, 4'b1000, "wrap_setup");
    add(1'b1, 4'b0011, 4'b0001, "wrap_to_0");
    add(1'b1, 4'b0010, 4'b0010, "wrap_next");
    add(1'b1, 4'b0100, 4'b0100, "midrst_setup");
    add(1'b0, 4'b0100, 4'b0001, "midrst_assert");
    add(1'b1, 4'b0100, 4'b0100, "midrst_release");
    add(1'b0, 4'bxxxx, 4'b0001, "reset_x_reqs");
    add(1'b1, 4'b0000, 4'b0001, "park_after_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].rq, vecs[i].name);
      chk({vecs[i].name, "/table"}, grants, vecs[i].exp);
    end

    // Fairness: all masters keep requesting; the owner drops for one cycle
    // each round, so ownership must walk 0,1,2,3,0,...
    step(1'b1, 4'b1111, "fair_hold");
    chk("fair_hold/table", grants, 4'b0001);
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      r = 4'b1111 & ~(4'b0001 << cur);
      step(1'b1, r, "fair_rotate");
      cur = (cur + 1) % N;
      chk("fair_rotate/table", grants, 4'b0001 << cur);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 31) == 0) ? 1'b0 : 1'b1;
      r  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      step(rs, r, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
